plic_target: RTL
================

Name: plic_target

Overview:
- Downstream stage of the per-source interrupt gateways. Takes their level-held request lines and applies per-source priority, enable mask and target threshold.
- Drives a single registered machine-external interrupt line to the core.
- Implements the claim/complete handshake over a small word-addressed register bus. On a valid complete it returns a one-cycle completion pulse to the matching gateway, which re-arms that gateway.

Parameters:
- N_SRC, 8, number of interrupt sources. Source IDs are 1..N_SRC; ID 0 means "no interrupt".
- PRIO_W, 3, priority and threshold field width. Priority 0 means the source is disabled.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- src_req_i  in  N_SRC  gateway requests; bit k is source ID k+1, held high until completed
- req_complete_o  out  N_SRC  one-cycle completion pulse to gateway; bit k is ID k+1
- bus_addr_i  in  8  word address
- bus_we_i  in  1  write strobe, single cycle
- bus_re_i  in  1  read strobe, single cycle; mutually exclusive with bus_we_i
- bus_wdata_i  in  32  write data
- bus_rdata_o  out  32  read data, registered
- bus_rvalid_o  out  1  high the cycle after an accepted read
- irq_o  out  1  interrupt to core, registered

Behaviour:
- Reset clears: prio[*]=0, enable=0, threshold=0, in_service=0, req_complete_o=0, bus_rdata_o=0, bus_rvalid_o=0, irq_o=0. Reset mid-handshake drops every claim; no completion pulse is emitted.
- Register map (word addresses):
  - 0x01..N_SRC: prio[id], bits [PRIO_W-1:0], R/W.
  - 0x20: enable, bits [N_SRC-1:0], R/W.
  - 0x21: threshold, R/W.
  - 0x22: claim (read) / complete (write).
  - 0x23: pending, RO, = src_req_i & ~in_service.
  - Unmapped reads return 0; unmapped writes are ignored. Write bits above the field width are dropped.
- Eligibility: source k is eligible when pending[k] & enable[k] & (prio[k] > threshold).
- Winner (combinational): the eligible source with the highest prio. Ties go to the lowest ID. winner_id = 0 when no source is eligible.
- irq_o is registered: irq_o <= (winner_id != 0). This gives 1 cycle latency from a gateway request (or config change) to irq_o.
- Claim: bus_re_i at 0x22.
  - Next cycle: bus_rdata_o = winner_id as sampled in the read cycle, and bus_rvalid_o = 1.
  - If winner_id != 0, in_service[winner_id] is set at the same edge.
  - A claim returning 0 changes no state.
  - Back-to-back claims never return the same ID, because in_service is updated before the next winner evaluation.
- Complete: bus_we_i at 0x22 with wdata = id.
  - If 1 <= id <= N_SRC and in_service[id]=1: at the next edge clear in_service[id] and assert req_complete_o[id-1] for exactly one cycle.
  - If id is out of range or the source is not in service, the write is ignored and no pulse is emitted.
- A source stays excluded from arbitration while in_service, even though its gateway keeps src_req_i high.
  - After the completion pulse the gateway drops its request the following cycle.
  - pending may show 1 for that source for one cycle during this window; that is accepted.
- Priority, enable and threshold changes take effect on the winner immediately and on irq_o one cycle later.
- A disabled or low-priority source may still be claimed-pending. Disabling a source while it is in service does not clear in_service; completion still works.
- Completion pulses for different IDs on consecutive cycles are allowed. Only one completion can occur per cycle.

Decomposition:
- Shared package (plic_pkg) holds:
  - register address constants (PLIC_PRIO_BASE, PLIC_ENABLE, PLIC_THRESH, PLIC_CLAIM, PLIC_PENDING);
  - default N_SRC and PRIO_W;
  - the ID width, computed as clog2(N_SRC+1).
- One sub-module, plic_prio_arb: a purely combinational max-priority/lowest-ID tree taking the eligible vector and the flattened priorities, returning winner_id and winner_prio. It is reusable for multi-target extensions.

Test Plan:
- Setup: prio[3]=5, enable=0x04, threshold=2. Raise src_req_i[2]. Expect irq_o=1 one cycle later; claim returns 3; irq_o falls the cycle after the claim.
- Tie and priority:
  - Sources 2 and 5 both at prio 4, both enabled and requesting: claim returns 2; second claim returns 5; third claim returns 0.
  - Raising prio[5] to 6 before the first claim makes the first claim return 5.
- Threshold: prio[1]=3, threshold=3, source 1 requesting: irq_o stays 0 and claim returns 0. Setting threshold=2 makes irq_o=1 one cycle later.
- Complete:
  - Claim 3, then write 3 to 0x22: req_complete_o=0x04 for exactly one cycle. With the gateway re-asserting, source 3 becomes claimable again.
  - Writing 3 a second time gives no pulse.
  - Writing 0 or 9 gives no pulse and no state change.
- Reset mid-operation: claim 3, assert rst_n=0 asynchronously mid-cycle. All outputs go to 0 immediately, in_service is cleared, and no completion pulse is emitted after release.

Source files
------------

// File: rtl/plic_pkg.sv
// Shared constants for the PLIC target: register word addresses,
// default source count / priority width, and the source-ID width helper.
// No ports; imported by plic_prio_arb and plic_target.
package plic_pkg;

  localparam int PLIC_N_SRC  = 8;
  localparam int PLIC_PRIO_W = 3;

  // Word addresses on the register bus.
  localparam logic [7:0] PLIC_PRIO_BASE = 8'h01; // prio[id] at PLIC_PRIO_BASE + id - 1
  localparam logic [7:0] PLIC_ENABLE    = 8'h20;
  localparam logic [7:0] PLIC_THRESH    = 8'h21;
  localparam logic [7:0] PLIC_CLAIM     = 8'h22;
  localparam logic [7:0] PLIC_PENDING   = 8'h23;

  // IDs run 0..n, with 0 meaning "no interrupt".
  function automatic int plic_id_width(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int PLIC_ID_W = plic_id_width(PLIC_N_SRC);

endpackage

// File: rtl/plic_prio_arb.sv
// Combinational max-priority selector: picks the eligible source with the
// highest priority, ties resolved toward the lowest ID; ID 0 when none eligible.
// Ports: eligible_i (per source), prio_i (flattened priorities), winner_id_o, winner_prio_o.
module plic_prio_arb
  import plic_pkg::*;
#(
  parameter int N_SRC  = PLIC_N_SRC,
  parameter int PRIO_W = PLIC_PRIO_W,
  parameter int ID_W   = plic_id_width(N_SRC)
) (
  input  logic [N_SRC-1:0]        eligible_i,
  input  logic [N_SRC*PRIO_W-1:0] prio_i,
  output logic [ID_W-1:0]         winner_id_o,
  output logic [PRIO_W-1:0]       winner_prio_o
);

  logic found;

  // Ascending scan with a strict '>' keeps the lowest ID on equal priority.
  always_comb begin
    found         = 1'b0;
    winner_id_o   = '0;
    winner_prio_o = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (eligible_i[k] && (!found || (prio_i[k*PRIO_W +: PRIO_W] > winner_prio_o))) begin
        found         = 1'b1;
        winner_id_o   = ID_W'(k + 1);
        winner_prio_o = prio_i[k*PRIO_W +: PRIO_W];
      end
    end
  end

endmodule

// File: rtl/plic_target.sv
// Single-target PLIC stage: priority/enable/threshold filtering of gateway
// requests, registered irq_o, and claim/complete over a word-addressed bus.
// Ports: src_req_i/req_complete_o (gateways), bus_* (register bus), irq_o (core).
module plic_target
  import plic_pkg::*;
#(
  parameter int N_SRC  = PLIC_N_SRC,
  parameter int PRIO_W = PLIC_PRIO_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_SRC-1:0]  src_req_i,
  output logic [N_SRC-1:0]  req_complete_o,
  input  logic [7:0]        bus_addr_i,
  input  logic              bus_we_i,
  input  logic              bus_re_i,
  input  logic [31:0]       bus_wdata_i,
  output logic [31:0]       bus_rdata_o,
  output logic              bus_rvalid_o,
  output logic              irq_o
);

  localparam int ID_W = plic_id_width(N_SRC);

  logic [N_SRC*PRIO_W-1:0] prio_q, prio_d;
  logic [N_SRC-1:0]        enable_q, enable_d;
  logic [PRIO_W-1:0]       thresh_q, thresh_d;
  logic [N_SRC-1:0]        in_service_q, in_service_d;
  logic [N_SRC-1:0]        req_complete_q, req_complete_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    rvalid_q;
  logic                    irq_q, irq_d;

  logic [N_SRC-1:0]        pending, eligible;
  logic [N_SRC-1:0]        claim_oh, cmpl_oh;
  logic [ID_W-1:0]         winner_id;
  logic [PRIO_W-1:0]       winner_prio;
  logic                    claim_rd, cmpl_wr;

  assign pending  = src_req_i & ~in_service_q;
  assign claim_rd = bus_re_i && (bus_addr_i == PLIC_CLAIM);
  assign cmpl_wr  = bus_we_i && (bus_addr_i == PLIC_CLAIM);

  always_comb begin
    eligible = '0;
    for (int k = 0; k < N_SRC; k++) begin
      eligible[k] = pending[k] && enable_q[k] && (prio_q[k*PRIO_W +: PRIO_W] > thresh_q);
    end
  end

  plic_prio_arb #(
    .N_SRC  (N_SRC),
    .PRIO_W (PRIO_W),
    .ID_W   (ID_W)
  ) u_arb (
    .eligible_i    (eligible),
    .prio_i        (prio_q),
    .winner_id_o   (winner_id),
    .winner_prio_o (winner_prio)
  );

  // One-hot forms of the claimed and completed IDs. Matching the full 32-bit
  // write data against each valid ID rejects 0 and out-of-range IDs for free.
  always_comb begin
    claim_oh = '0;
    cmpl_oh  = '0;
    for (int k = 0; k < N_SRC; k++) begin
      claim_oh[k] = claim_rd && (winner_id == ID_W'(k + 1));
      cmpl_oh[k]  = cmpl_wr && (bus_wdata_i == 32'(k + 1)) && in_service_q[k];
    end
  end

  // Claim and complete never coincide (read/write strobes are exclusive).
  assign in_service_d   = (in_service_q | claim_oh) & ~cmpl_oh;
  assign req_complete_d = cmpl_oh;

  // The arbiter only reports eligible winners, whose priority is above
  // threshold and therefore non-zero.
  assign irq_d = (winner_id != '0) && (winner_prio != '0);

  // Configuration writes; bits above each field width are dropped.
  always_comb begin
    prio_d   = prio_q;
    enable_d = enable_q;
    thresh_d = thresh_q;
    if (bus_we_i) begin
      for (int k = 0; k < N_SRC; k++) begin
        if (bus_addr_i == PLIC_PRIO_BASE + 8'(k)) begin
          prio_d[k*PRIO_W +: PRIO_W] = bus_wdata_i[PRIO_W-1:0];
        end
      end
      if (bus_addr_i == PLIC_ENABLE) enable_d = bus_wdata_i[N_SRC-1:0];
      if (bus_addr_i == PLIC_THRESH) thresh_d = bus_wdata_i[PRIO_W-1:0];
    end
  end

  // Read mux; unmapped addresses return 0.
  always_comb begin
    rdata_d = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (bus_addr_i == PLIC_PRIO_BASE + 8'(k)) begin
        rdata_d[PRIO_W-1:0] = prio_q[k*PRIO_W +: PRIO_W];
      end
    end
    case (bus_addr_i)
      PLIC_ENABLE:  rdata_d[N_SRC-1:0]  = enable_q;
      PLIC_THRESH:  rdata_d[PRIO_W-1:0] = thresh_q;
      PLIC_CLAIM:   rdata_d[ID_W-1:0]   = winner_id;
      PLIC_PENDING: rdata_d[N_SRC-1:0]  = pending;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q         <= '0;
      enable_q       <= '0;
      thresh_q       <= '0;
      in_service_q   <= '0;
      req_complete_q <= '0;
      rdata_q        <= '0;
      rvalid_q       <= 1'b0;
      irq_q          <= 1'b0;
    end else begin
      prio_q         <= prio_d;
      enable_q       <= enable_d;
      thresh_q       <= thresh_d;
      in_service_q   <= in_service_d;
      req_complete_q <= req_complete_d;
      rvalid_q       <= bus_re_i;
      irq_q          <= irq_d;
      if (bus_re_i) rdata_q <= rdata_d;
    end
  end

  assign req_complete_o = req_complete_q;
  assign bus_rdata_o    = rdata_q;
  assign bus_rvalid_o   = rvalid_q;
  assign irq_o          = irq_q;

endmodule
